// File: rtl/ahb_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bridge_arbiter
// Brief    : Round-robin arbiter sharing the AHB-to-APB bridge slave port
//            among NUM_MASTERS requesters; sequences address then data phase.
//            Optional data-phase watchdog enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_HOLD    = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      Hclk,
    input  logic                      Hreset,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [NUM_MASTERS*AW-1:0] m_addr,
    input  logic [NUM_MASTERS*DW-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_grant,
    output logic [NUM_MASTERS-1:0]    m_done,
    output logic [NUM_MASTERS-1:0]    m_err,
    output logic [DW-1:0]             m_rdata,
    output logic [1:0]                Htrans,
    output logic                      Hwrite,
    output logic [AW-1:0]             Haddr,
    output logic [DW-1:0]             Hwdata,
    output logic                      Hreadyin,
    input  logic                      Hreadyout,
    input  logic [1:0]                Hresp,
    input  logic [DW-1:0]             Hrdata
);

    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [OW:0]   NUM_M_W    = (OW + 1)'(NUM_MASTERS);
    localparam logic [OW-1:0] LAST_M     = OW'(NUM_MASTERS - 1);
    localparam logic [HW-1:0] MAX_HOLD_W = HW'(MAX_HOLD);

    logic [1:0]    state;
    logic [OW-1:0] owner;
    logic [OW-1:0] rr_ptr;
    logic [HW-1:0] hold_cnt;

    logic [OW-1:0] owner_succ;
    logic [OW-1:0] arb_base;
    logic [OW-1:0] arb_idx;
    logic [OW-1:0] sel_idx;
    logic [OW:0]   cand;
    logic          arb_valid;
    logic          xfer_ok;
    logic          timeout_hit;
    logic          keep_owner;
    logic          release_owner;
    logic          start_new;

    assign owner_succ = (owner == LAST_M) ? '0 : owner + OW'(1);

    // On release the search starts just past the outgoing owner, so that
    // requesters raised in the completion cycle compete fairly.
    assign arb_base = (state == ST_DATA) ? owner_succ : rr_ptr;

    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, arb_base} + (OW + 1)'(i);
            if (cand >= NUM_M_W) begin
                cand = cand - NUM_M_W;
            end
            if (!arb_valid && m_req[cand[OW-1:0]]) begin
                arb_valid = 1'b1;
                arb_idx   = cand[OW-1:0];
            end
        end
    end

    assign xfer_ok       = (state == ST_DATA) && Hreadyout;
    assign keep_owner    = xfer_ok && m_req[owner] && (hold_cnt < MAX_HOLD_W);
    assign release_owner = (xfer_ok && !keep_owner) || timeout_hit;
    assign start_new     = ((state == ST_IDLE) || release_owner) && arb_valid;
    assign sel_idx       = keep_owner ? owner : arb_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] to_cnt;

    // Counts consecutive stalled data-phase cycles; any ready or phase change clears it.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            to_cnt <= '0;
        end else if ((state != ST_DATA) || Hreadyout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    assign timeout_hit = (state == ST_DATA) && !Hreadyout && (to_cnt == TO_LAST);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            m_grant  <= '0;
            m_done   <= '0;
            m_err    <= '0;
            m_rdata  <= '0;
            Htrans   <= HTRANS_IDLE;
            Hwrite   <= 1'b0;
            Haddr    <= '0;
            Hwdata   <= '0;
            Hreadyin <= 1'b0;
        end else begin
            m_done <= '0;
            m_err  <= '0;

            if (xfer_ok) begin
                m_done[owner] <= 1'b1;
                if (Hresp == HRESP_ERROR) begin
                    m_err[owner] <= 1'b1;
                end
                if (!Hwrite) begin
                    m_rdata <= Hrdata;
                end
            end

            if (timeout_hit) begin
                m_err[owner] <= 1'b1;
            end

            if (release_owner) begin
                rr_ptr <= owner_succ;
            end

            if (keep_owner || start_new) begin
                state    <= ST_ADDR;
                owner    <= sel_idx;
                m_grant  <= NUM_MASTERS'(1) << sel_idx;
                Htrans   <= HTRANS_NONSEQ;
                Hwrite   <= m_write[sel_idx];
                Haddr    <= m_addr[sel_idx*AW +: AW];
                Hreadyin <= 1'b1;
                hold_cnt <= keep_owner ? hold_cnt + HW'(1) : HW'(1);
            end else if (release_owner) begin
                state    <= ST_IDLE;
                m_grant  <= '0;
                Htrans   <= HTRANS_IDLE;
                Hreadyin <= 1'b0;
                hold_cnt <= '0;
            end else if (state == ST_ADDR) begin
                state  <= ST_DATA;
                Htrans <= HTRANS_IDLE;
                Hwdata <= m_wdata[owner*DW +: DW];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_bridge_arbiter
// Brief    : Self-checking bench for ahb_bridge_arbiter: directed scenarios
//            plus randomized traffic against a transfer-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_bridge_arbiter;

    localparam int N           = 4;
    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int MAX_HOLD    = 8;
    localparam int TIMEOUT_CYC = 64;

    logic              Hclk;
    logic              Hreset;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_write;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N-1:0]      m_grant;
    logic [N-1:0]      m_done;
    logic [N-1:0]      m_err;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        Htrans;
    logic              Hwrite;
    logic [AW-1:0]     Haddr;
    logic [DW-1:0]     Hwdata;
    logic              Hreadyin;
    logic              Hreadyout;
    logic [1:0]        Hresp;
    logic [DW-1:0]     Hrdata;

    int n_checks = 0;
    int n_errors = 0;

    ahb_bridge_arbiter #(
        .NUM_MASTERS (N),
        .AW          (AW),
        .DW          (DW),
        .MAX_HOLD    (MAX_HOLD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .m_req     (m_req),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_grant   (m_grant),
        .m_done    (m_done),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .Htrans    (Htrans),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hreadyin  (Hreadyin),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic tick;
        @(posedge Hclk);
        #1;
    endtask

    task automatic clear_inputs;
        m_req     = '0;
        m_write   = '0;
        m_addr    = '0;
        m_wdata   = '0;
        Hreadyout = 1'b0;
        Hresp     = 2'b00;
        Hrdata    = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        Hreset = 1'b1;
        repeat (2) @(posedge Hclk);
        #1;
        Hreset = 1'b0;
    endtask

    // First requester at or after 'start', wrapping; -1 when nobody asks.
    function automatic int rr_pick(input logic [N-1:0] req, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset;
        clear_inputs();
        Hreset = 1'b1;
        #3;
        n_checks++; if (m_grant  !== 4'b0)  begin n_errors++; $display("FAIL reset_grant: got %b want 0000", m_grant); end
        n_checks++; if (m_done   !== 4'b0)  begin n_errors++; $display("FAIL reset_done: got %b want 0000", m_done); end
        n_checks++; if (m_err    !== 4'b0)  begin n_errors++; $display("FAIL reset_err: got %b want 0000", m_err); end
        n_checks++; if (m_rdata  !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
        n_checks++; if (Htrans   !== 2'b00) begin n_errors++; $display("FAIL reset_htrans: got %b want 00", Htrans); end
        n_checks++; if (Hwrite   !== 1'b0)  begin n_errors++; $display("FAIL reset_hwrite: got %b want 0", Hwrite); end
        n_checks++; if (Haddr    !== 32'h0) begin n_errors++; $display("FAIL reset_haddr: got %h want 0", Haddr); end
        n_checks++; if (Hwdata   !== 32'h0) begin n_errors++; $display("FAIL reset_hwdata: got %h want 0", Hwdata); end
        n_checks++; if (Hreadyin !== 1'b0)  begin n_errors++; $display("FAIL reset_hreadyin: got %b want 0", Hreadyin); end
        repeat (2) @(posedge Hclk);
        #1;
        Hreset = 1'b0;
        tick();
        n_checks++; if (m_grant !== 4'b0 || Htrans !== 2'b00) begin
            n_errors++; $display("FAIL reset_idle_quiet: grant %b htrans %b want 0000/00", m_grant, Htrans);
        end
    endtask

    task automatic test_single;
        do_reset();
        m_req[1]          = 1'b1;
        m_write[1]        = 1'b1;
        m_addr[1*AW +: AW]  = 32'h8000_0004;
        m_wdata[1*DW +: DW] = 32'hA5A5_0001;
        tick();
        n_checks++; if (m_grant !== 4'b0010) begin n_errors++; $display("FAIL single_grant: got %b want 0010", m_grant); end
        n_checks++; if (Htrans !== 2'b10) begin n_errors++; $display("FAIL single_nonseq: got %b want 10", Htrans); end
        n_checks++; if (Haddr !== 32'h8000_0004 || Hwrite !== 1'b1 || Hreadyin !== 1'b1) begin
            n_errors++; $display("FAIL single_addr_phase: haddr %h hwrite %b hreadyin %b want 80000004/1/1", Haddr, Hwrite, Hreadyin);
        end
        tick();
        n_checks++; if (Htrans !== 2'b00) begin n_errors++; $display("FAIL single_data_htrans: got %b want 00", Htrans); end
        n_checks++; if (Hwdata !== 32'hA5A5_0001) begin n_errors++; $display("FAIL single_hwdata: got %h want a5a50001", Hwdata); end
        n_checks++; if (m_done !== 4'b0) begin n_errors++; $display("FAIL single_early_done: got %b want 0000", m_done); end
        m_req     = '0;
        Hreadyout = 1'b1;
        tick();
        n_checks++; if (m_done !== 4'b0010) begin n_errors++; $display("FAIL single_done: got %b want 0010", m_done); end
        n_checks++; if (m_grant !== 4'b0 || Htrans !== 2'b00 || Hreadyin !== 1'b0) begin
            n_errors++; $display("FAIL single_release: grant %b htrans %b hreadyin %b want 0000/00/0", m_grant, Htrans, Hreadyin);
        end
        Hreadyout = 1'b0;
        tick();
        n_checks++; if (m_done !== 4'b0) begin n_errors++; $display("FAIL single_done_pulse: got %b want 0000", m_done); end
    endtask

    task automatic test_wait_states;
        int done_seen;
        done_seen = 0;
        do_reset();
        m_req[0]          = 1'b1;
        m_write[0]        = 1'b0;
        m_addr[0 +: AW]   = 32'h0000_1000;
        tick();
        n_checks++; if (m_grant !== 4'b0001 || Htrans !== 2'b10 || Hwrite !== 1'b0) begin
            n_errors++; $display("FAIL wait_addr_phase: grant %b htrans %b hwrite %b want 0001/10/0", m_grant, Htrans, Hwrite);
        end
        tick();
        m_req[0] = 1'b0;
        for (int w = 0; w < 5; w++) begin
            tick();
            if (m_done != 0) done_seen++;
            n_checks++; if (Htrans !== 2'b00 || m_grant !== 4'b0001) begin
                n_errors++; $display("FAIL wait_stall_%0d: htrans %b grant %b want 00/0001", w, Htrans, m_grant);
            end
        end
        Hreadyout = 1'b1;
        Hrdata    = 32'hDEAD_BEEF;
        tick();
        if (m_done != 0) done_seen++;
        n_checks++; if (m_done !== 4'b0001) begin n_errors++; $display("FAIL wait_done: got %b want 0001", m_done); end
        n_checks++; if (m_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wait_rdata: got %h want deadbeef", m_rdata); end
        Hreadyout = 1'b0;
        Hrdata    = 32'h0;
        repeat (2) begin
            tick();
            if (m_done != 0) done_seen++;
        end
        n_checks++; if (done_seen !== 1) begin n_errors++; $display("FAIL wait_done_count: got %0d want 1", done_seen); end
        n_checks++; if (m_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wait_rdata_hold: got %h want deadbeef", m_rdata); end
    endtask

    task automatic test_error;
        do_reset();
        m_req[3]            = 1'b1;
        m_write[3]          = 1'b1;
        m_addr[3*AW +: AW]  = 32'h4000_0010;
        m_wdata[3*DW +: DW] = 32'h1234_abcd;
        tick();
        tick();
        m_req     = '0;
        Hreadyout = 1'b1;
        Hresp     = 2'b01;
        tick();
        n_checks++; if (m_err !== 4'b1000) begin n_errors++; $display("FAIL error_err: got %b want 1000", m_err); end
        n_checks++; if (m_done !== 4'b1000) begin n_errors++; $display("FAIL error_done: got %b want 1000", m_done); end
        Hreadyout = 1'b0;
        Hresp     = 2'b00;
        tick();
        n_checks++; if (m_err !== 4'b0) begin n_errors++; $display("FAIL error_pulse: got %b want 0000", m_err); end
    endtask

    task automatic test_fairness;
        int k;
        int exp_m;
        logic [N-1:0] one;
        one = 1;
        k   = 0;
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW] = 32'h100 * (i + 1);
        end
        m_write   = '1;
        m_req     = '1;
        Hreadyout = 1'b1;
        for (int c = 0; c < 200 && k < 4 * MAX_HOLD + 1; c++) begin
            tick();
            if (Htrans == 2'b10) begin
                exp_m = (k / MAX_HOLD) % N;
                n_checks++; if (m_grant !== (one << exp_m) || Haddr !== 32'(32'h100 * (exp_m + 1))) begin
                    n_errors++; $display("FAIL fairness_grant_%0d: grant %b haddr %h want master %0d", k, m_grant, Haddr, exp_m);
                end
                k++;
            end
        end
        n_checks++; if (k !== 4 * MAX_HOLD + 1) begin
            n_errors++; $display("FAIL fairness_count: got %0d transfers want %0d", k, 4 * MAX_HOLD + 1);
        end
        clear_inputs();
        repeat (4) tick();
    endtask

    task automatic test_reset_mid;
        int bad;
        bad = 0;
        do_reset();
        m_req[2]            = 1'b1;
        m_write[2]          = 1'b1;
        m_addr[2*AW +: AW]  = 32'h1234_5678;
        m_wdata[2*DW +: DW] = 32'h0BAD_F00D;
        tick();
        tick();
        n_checks++; if (Hwdata !== 32'h0BAD_F00D || Hreadyin !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_data_phase: hwdata %h hreadyin %b want 0badf00d/1", Hwdata, Hreadyin);
        end
        Hreadyout = 1'b1;
        #2;
        Hreset = 1'b1;
        #1;
        n_checks++; if (m_grant !== 4'b0 || Htrans !== 2'b00 || Hreadyin !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_ctrl: grant %b htrans %b hreadyin %b want 0000/00/0", m_grant, Htrans, Hreadyin);
        end
        n_checks++; if (Haddr !== 32'h0 || Hwdata !== 32'h0 || Hwrite !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_bus: haddr %h hwdata %h hwrite %b want 0/0/0", Haddr, Hwdata, Hwrite);
        end
        @(posedge Hclk);
        #1;
        Hreset    = 1'b0;
        m_req     = '0;
        Hreadyout = 1'b0;
        repeat (3) begin
            tick();
            if (m_done != 0 || m_err != 0 || m_grant != 0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rstmid_no_completion: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_random(input int cycles);
        logic [N-1:0]    s_req, s_write;
        logic [N*AW-1:0] s_addr;
        logic [N*DW-1:0] s_wdata;
        logic            s_hready;
        logic [1:0]      s_hresp;
        logic [DW-1:0]   s_hrdata;
        logic [N-1:0]    one, exp_grant, exp_done, exp_err;
        logic [AW-1:0]   exp_addr;
        logic [DW-1:0]   exp_wdata, exp_rdata;
        logic            exp_write;
        bit              busy, in_data;
        int              owner, run, rr, nxt;
        one = 1; busy = 0; in_data = 0; owner = 0; run = 0; rr = 0;
        exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_write = 1'b0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            s_req = m_req; s_write = m_write; s_addr = m_addr; s_wdata = m_wdata;
            s_hready = Hreadyout; s_hresp = Hresp; s_hrdata = Hrdata;
            tick();
            exp_done = '0;
            exp_err  = '0;
            nxt      = -1;
            if (!busy) begin
                nxt = rr_pick(s_req, rr);
            end else if (!in_data) begin
                in_data   = 1;
                exp_wdata = s_wdata[owner*DW +: DW];
            end else if (s_hready) begin
                exp_done[owner] = 1'b1;
                if (s_hresp == 2'b01) exp_err[owner] = 1'b1;
                if (!exp_write) exp_rdata = s_hrdata;
                if (s_req[owner] && run < MAX_HOLD) begin
                    run++;
                    in_data  = 0;
                    exp_addr = s_addr[owner*AW +: AW];
                    exp_write = s_write[owner];
                end else begin
                    rr   = (owner + 1) % N;
                    busy = 0;
                    nxt  = rr_pick(s_req, rr);
                end
            end
            if (nxt >= 0) begin
                busy = 1; in_data = 0; owner = nxt; run = 1;
                exp_addr  = s_addr[owner*AW +: AW];
                exp_write = s_write[owner];
            end
            exp_grant = busy ? (one << owner) : '0;
            n_checks++; if (m_grant !== exp_grant) begin n_errors++; $display("FAIL rand_grant c%0d: got %b want %b", c, m_grant, exp_grant); end
            n_checks++; if (Htrans !== ((busy && !in_data) ? 2'b10 : 2'b00) || Hreadyin !== busy) begin
                n_errors++; $display("FAIL rand_htrans c%0d: htrans %b hreadyin %b busy %0d addr_phase %0d", c, Htrans, Hreadyin, busy, !in_data);
            end
            n_checks++; if (m_done !== exp_done || m_err !== exp_err) begin
                n_errors++; $display("FAIL rand_done c%0d: done %b err %b want %b %b", c, m_done, m_err, exp_done, exp_err);
            end
            n_checks++; if (m_rdata !== exp_rdata) begin n_errors++; $display("FAIL rand_rdata c%0d: got %h want %h", c, m_rdata, exp_rdata); end
            if (busy) begin
                n_checks++; if (Haddr !== exp_addr || Hwrite !== exp_write) begin
                    n_errors++; $display("FAIL rand_addr c%0d: haddr %h hwrite %b want %h %b", c, Haddr, Hwrite, exp_addr, exp_write);
                end
            end
            if (busy && in_data) begin
                n_checks++; if (Hwdata !== exp_wdata) begin n_errors++; $display("FAIL rand_hwdata c%0d: got %h want %h", c, Hwdata, exp_wdata); end
            end
            for (int i = 0; i < N; i++) begin
                if (m_req[i]) begin
                    if (m_done[i]) begin
                        if ($urandom_range(0, 1) == 0) begin
                            m_req[i] = 1'b0;
                        end else begin
                            m_addr[i*AW +: AW]  = $urandom;
                            m_wdata[i*DW +: DW] = $urandom;
                        end
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    m_req[i]            = 1'b1;
                    m_write[i]          = 1'($urandom_range(0, 1));
                    m_addr[i*AW +: AW]  = $urandom;
                    m_wdata[i*DW +: DW] = $urandom;
                end
            end
            Hreadyout = ($urandom_range(0, 3) != 0);
            Hresp     = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
            Hrdata    = $urandom;
        end
        clear_inputs();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        do_reset();
        m_req[2]   = 1'b1;
        m_write[2] = 1'b1;
        tick();
        tick();
        m_req[0] = 1'b1;
        while (n < TIMEOUT_CYC + 20 && !seen) begin
            tick();
            n++;
            if (m_err != 0) seen = 1;
        end
        n_checks++; if (!seen || n !== TIMEOUT_CYC) begin
            n_errors++; $display("FAIL timeout_cycle: seen %0d after %0d cycles want %0d", seen, n, TIMEOUT_CYC);
        end
        n_checks++; if (m_err !== 4'b0100 || m_done !== 4'b0) begin
            n_errors++; $display("FAIL timeout_pulse: err %b done %b want 0100/0000", m_err, m_done);
        end
        n_checks++; if (m_grant !== 4'b0001 || Htrans !== 2'b10) begin
            n_errors++; $display("FAIL timeout_regrant: grant %b htrans %b want 0001/10", m_grant, Htrans);
        end
        clear_inputs();
    endtask
`endif

    initial begin
        Hreset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_wait_states();
        test_error();
        test_fairness();
        test_reset_mid();
        test_random(1500);
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
